// File: rtl/video_timing_gen.sv
// video_timing_gen
//
// Raster timing generator for MCR/Gottlieb-style video. It steps a pixel/line
// counter pair on ce_pix and produces these registered outputs:
//   - blanking
//   - active-low syncs
//   - data-enable
//   - line/frame strobes
// The left-edge trim and the hsync offset are shadowed and only take effect at
// frame boundaries.
//
// Ports:
//   clk_sys      in   system clock
//   reset        in   synchronous, active-high
//   ce_pix       in   pixel clock-enable
//   left_trim    in   [3:0]   leftmost active columns to blank
//   hs_adj       in   [3:0]   signed hsync window shift, -8..+7
//   rgb_in       in   [RGB_W] pixel colour from the board
//   rgb_out      out  [RGB_W] rgb_in gated by de
//   hcnt, vcnt   out  current pixel column / line
//   hb, vb       out  blanking, active high
//   hs, vs       out  syncs, active low
//   de           out  ~hb & ~vb
//   line_start   out  pulse when hcnt becomes 0
//   frame_start  out  pulse when (hcnt,vcnt) becomes (0,0)

module video_timing_gen #(
    parameter int H_ACTIVE = 256,
    parameter int H_TOTAL  = 318,
    parameter int HS_START = 283,
    parameter int HS_END   = 303,
    parameter int V_ACTIVE = 240,
    parameter int V_TOTAL  = 256,
    parameter int VS_START = 251,
    parameter int VS_END   = 254,
    parameter int RGB_W    = 24,
    localparam int HW      = $clog2(H_TOTAL),
    localparam int VW      = $clog2(V_TOTAL)
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             ce_pix,
    input  logic [3:0]       left_trim,
    input  logic [3:0]       hs_adj,
    input  logic [RGB_W-1:0] rgb_in,
    output logic [RGB_W-1:0] rgb_out,
    output logic [HW-1:0]    hcnt,
    output logic [VW-1:0]    vcnt,
    output logic             hb,
    output logic             vb,
    output logic             hs,
    output logic             vs,
    output logic             de,
    output logic             line_start,
    output logic             frame_start
);

    if (HS_START - 8 < H_ACTIVE) begin : g_chk_hs_start
        $error("HS_START-8 must be >= H_ACTIVE");
    end
    if (HS_END + 7 > H_TOTAL) begin : g_chk_hs_end
        $error("HS_END+7 must be <= H_TOTAL");
    end
    if (HS_START >= HS_END) begin : g_chk_hs_order
        $error("HS_START must be < HS_END");
    end
    if (!(V_ACTIVE <= VS_START && VS_START < VS_END && VS_END <= V_TOTAL)) begin : g_chk_v
        $error("need V_ACTIVE <= VS_START < VS_END <= V_TOTAL");
    end
    if (H_ACTIVE <= 15) begin : g_chk_h_active
        $error("H_ACTIVE must be > 15");
    end

    logic [3:0]    trim_q;
    logic [3:0]    adj_q;

    logic          h_wrap;
    logic          v_wrap;
    logic          fs_nxt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic [3:0]    trim_nxt;
    logic [3:0]    adj_nxt;
    logic [HW:0]   h_ext;
    logic [VW:0]   v_ext;
    logic [HW:0]   adj_ext;
    logic [HW:0]   hs_lo;
    logic [HW:0]   hs_hi;
    logic          hb_nxt;
    logic          vb_nxt;
    logic          hs_nxt;
    logic          vs_nxt;

    always_comb begin
        h_wrap = (hcnt == HW'(H_TOTAL - 1));
        v_wrap = (vcnt == VW'(V_TOTAL - 1));
        h_nxt  = h_wrap ? '0 : hcnt + HW'(1);
        v_nxt  = vcnt;
        if (h_wrap) begin
            v_nxt = v_wrap ? '0 : vcnt + VW'(1);
        end
        fs_nxt = h_wrap & v_wrap;

        // The first pixel of a new frame is decoded with the values being
        // captured on this very step, not the stale shadow copies.
        trim_nxt = fs_nxt ? left_trim : trim_q;
        adj_nxt  = fs_nxt ? hs_adj    : adj_q;

        // Comparisons are one bit wider than the counters so that limits equal
        // to the total (e.g. VS_END == V_TOTAL) and the offset hsync window fit.
        h_ext   = {1'b0, h_nxt};
        v_ext   = {1'b0, v_nxt};
        adj_ext = {{(HW - 3){adj_nxt[3]}}, adj_nxt};
        hs_lo   = (HW + 1)'(HS_START) + adj_ext;
        hs_hi   = (HW + 1)'(HS_END) + adj_ext;

        hb_nxt = (h_ext < {{(HW - 3){1'b0}}, trim_nxt}) | (h_ext >= (HW + 1)'(H_ACTIVE));
        vb_nxt = (v_ext >= (VW + 1)'(V_ACTIVE));
        hs_nxt = ~((h_ext >= hs_lo) & (h_ext < hs_hi));
        vs_nxt = ~((v_ext >= (VW + 1)'(VS_START)) & (v_ext < (VW + 1)'(VS_END)));
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hcnt        <= HW'(H_TOTAL - 1);
            vcnt        <= VW'(V_TOTAL - 1);
            hb          <= 1'b1;
            vb          <= 1'b1;
            hs          <= 1'b1;
            vs          <= 1'b1;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            trim_q      <= left_trim;
            adj_q       <= hs_adj;
        end else if (ce_pix) begin
            hcnt        <= h_nxt;
            vcnt        <= v_nxt;
            hb          <= hb_nxt;
            vb          <= vb_nxt;
            hs          <= hs_nxt;
            vs          <= vs_nxt;
            de          <= ~hb_nxt & ~vb_nxt;
            line_start  <= h_wrap;
            frame_start <= fs_nxt;
            trim_q      <= trim_nxt;
            adj_q       <= adj_nxt;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

    assign rgb_out = de ? rgb_in : '0;

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int H_ACTIVE = 20;
    localparam int H_TOTAL  = 48;
    localparam int HS_START = 30;
    localparam int HS_END   = 38;
    localparam int V_ACTIVE = 12;
    localparam int V_TOTAL  = 17;
    localparam int VS_START = 13;
    localparam int VS_END   = 15;
    localparam int RGB_W    = 24;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int FRAME    = H_TOTAL * V_TOTAL;

    logic             clk_sys = 1'b0;
    logic             reset;
    logic             ce_pix;
    logic [3:0]       left_trim;
    logic [3:0]       hs_adj;
    logic [RGB_W-1:0] rgb_in;
    logic [RGB_W-1:0] rgb_out;
    logic [HW-1:0]    hcnt;
    logic [VW-1:0]    vcnt;
    logic             hb, vb, hs, vs, de;
    logic             line_start, frame_start;

    always #5 clk_sys = ~clk_sys;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_END(HS_END),
        .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_END(VS_END),
        .RGB_W(RGB_W)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix),
        .left_trim(left_trim), .hs_adj(hs_adj), .rgb_in(rgb_in), .rgb_out(rgb_out),
        .hcnt(hcnt), .vcnt(vcnt), .hb(hb), .vb(vb), .hs(hs), .vs(vs), .de(de),
        .line_start(line_start), .frame_start(frame_start)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference: the raster position is a single linear pixel index.
    int pix;
    bit m_rst;
    int m_trim;
    int m_adj;
    bit m_ls;
    bit m_fs;
    int cyc = 0;
    int last_fs = -1;
    int exp_period = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (pix %0d)", tag, got, exp, pix);
        end
    endtask

    task automatic cycle(input bit r, input bit ce);
        int h, v;
        bit e_hb, e_vb, e_hs, e_vs, e_de;
        reset  = r;
        ce_pix = ce;
        @(posedge clk_sys);
        cyc++;
        if (r) begin
            m_rst   = 1'b1;
            pix     = FRAME - 1;
            m_trim  = int'(left_trim);
            m_adj   = int'($signed(hs_adj));
            m_ls    = 1'b0;
            m_fs    = 1'b0;
            last_fs = -1;
        end else if (ce) begin
            pix   = (pix + 1) % FRAME;
            m_rst = 1'b0;
            if (pix == 0) begin
                m_trim = int'(left_trim);
                m_adj  = int'($signed(hs_adj));
            end
            m_ls = (pix % H_TOTAL == 0);
            m_fs = (pix == 0);
        end else begin
            m_ls = 1'b0;
            m_fs = 1'b0;
        end
        #1;
        h = pix % H_TOTAL;
        v = pix / H_TOTAL;
        if (m_rst) begin
            e_hb = 1; e_vb = 1; e_hs = 1; e_vs = 1;
        end else begin
            e_hb = (h < m_trim) || (h >= H_ACTIVE);
            e_vb = (v >= V_ACTIVE);
            e_hs = !((h >= HS_START + m_adj) && (h < HS_END + m_adj));
            e_vs = !((v >= VS_START) && (v < VS_END));
        end
        e_de = !e_hb && !e_vb;
        chk("hcnt", 32'(hcnt), 32'(h));
        chk("vcnt", 32'(vcnt), 32'(v));
        chk("hb", 32'(hb), 32'(e_hb));
        chk("vb", 32'(vb), 32'(e_vb));
        chk("hs", 32'(hs), 32'(e_hs));
        chk("vs", 32'(vs), 32'(e_vs));
        chk("de", 32'(de), 32'(e_de));
        chk("line_start", 32'(line_start), 32'(m_ls));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("rgb_out", 32'(rgb_out), e_de ? 32'(rgb_in) : 32'd0);
        if (frame_start === 1'b1) begin
            if (exp_period != 0 && last_fs >= 0)
                chk("frame_period", 32'(cyc - last_fs), 32'(exp_period));
            last_fs = cyc;
        end
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (pix != target && guard < 2 * FRAME) begin
            rgb_in = RGB_W'($urandom);
            cycle(1'b0, 1'b1);
            guard++;
        end
        chk("run_to_reached", 32'(pix), 32'(target));
    endtask

    initial begin
        reset     = 1'b1;
        ce_pix    = 1'b0;
        left_trim = 4'd0;
        hs_adj    = 4'd0;
        rgb_in    = '1;
        pix       = FRAME - 1;
        m_rst     = 1'b1;
        m_trim    = 0;
        m_adj     = 0;
        repeat (3) cycle(1'b1, 1'b0);

        // Continuous ce_pix, occasional mid-frame control changes.
        exp_period = FRAME;
        for (int i = 0; i < 3 * FRAME + 5; i++) begin
            if ($urandom_range(0, 39) == 0) begin
                left_trim = 4'($urandom);
                hs_adj    = 4'($urandom);
            end
            rgb_in = RGB_W'($urandom);
            cycle(1'b0, 1'b1);
        end

        // Control change landing exactly on the frame_start step.
        run_to(FRAME - 1);
        left_trim = 4'd15;
        hs_adj    = 4'hD;
        cycle(1'b0, 1'b1);
        run_to(5 * H_TOTAL);
        left_trim = 4'd2;
        hs_adj    = 4'h7;
        run_to(FRAME - 1);
        cycle(1'b0, 1'b1);
        run_to(H_TOTAL + 10);

        // Mid-frame reset, asserted together with ce_pix.
        run_to(7 * H_TOTAL + 13);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Sparse random ce_pix with rare resets.
        exp_period = 0;
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                left_trim = 4'($urandom);
                hs_adj    = 4'($urandom);
            end
            rgb_in = RGB_W'($urandom);
            cycle($urandom_range(0, 1499) == 0, $urandom_range(0, 2) == 0);
        end

        // ce_pix every 10th clock.
        cycle(1'b1, 1'b0);
        exp_period = 10 * FRAME;
        last_fs    = -1;
        for (int k = 0; k < 2 * 10 * FRAME + 25; k++) begin
            rgb_in = RGB_W'($urandom);
            cycle(1'b0, (k % 10) == 9);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised raster timing generator for the MCR/Gottlieb-style arcade boards. It replaces the fixed 256x240 horizontal/vertical generator used in front of `arcade_video`. It produces the pixel counters, blanking, active-low syncs and a data-enable from a single clock with a pixel clock-enable. Beyond the fixed generator, it adds:
- a runtime left-edge trim (a generalised "column bug" fix);
- a runtime horizontal sync offset for monitor centring;
- frame and line strobes.

All of these runtime adjustments are applied only at frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, 256, visible pixels per line
- `H_TOTAL`, 318, pixels per line including blanking
- `HS_START`, 283, first pixel of horizontal sync (before offset)
- `HS_END`, 303, first pixel after horizontal sync (before offset)
- `V_ACTIVE`, 240, visible lines per frame
- `V_TOTAL`, 256, lines per frame
- `VS_START`, 251, first line of vertical sync
- `VS_END`, 254, first line after vertical sync
- `RGB_W`, 24, width of the colour bus
- Elaboration constraints:
  - `HS_START-8 >= H_ACTIVE`
  - `HS_END+7 <= H_TOTAL`
  - `HS_START < HS_END`
  - `V_ACTIVE <= VS_START < VS_END <= V_TOTAL`
  - `H_ACTIVE > 15`
  - Any violation is a `$error`.

Ports:
- `clk_sys`  in  1  system clock; every register is clocked here
- `reset`  in  1  synchronous, active-high
- `ce_pix`  in  1  pixel clock-enable; all state advances only when it is high
- `left_trim`  in  4  number of leftmost active columns to blank
- `hs_adj`  in  4  signed (two's complement) shift of the whole hsync window, range -8..+7 pixels
- `rgb_in`  in  `RGB_W`  pixel colour from the board
- `rgb_out`  out  `RGB_W`  `rgb_in` gated by `de`
- `hcnt`  out  `clog2(H_TOTAL)`  current pixel column
- `vcnt`  out  `clog2(V_TOTAL)`  current line
- `hb`, `vb`  out  1  horizontal/vertical blank, active high
- `hs`, `vs`  out  1  syncs, active low
- `de`  out  1  `~hb & ~vb`
- `line_start`  out  1  one-`clk_sys` pulse on the `ce_pix` cycle where `hcnt` becomes 0
- `frame_start`  out  1  one-`clk_sys` pulse on the `ce_pix` cycle where (`hcnt`,`vcnt`) becomes (0,0)

## Operation
- Counters:
  - On `ce_pix`, `hcnt` increments.
  - At `H_TOTAL-1`, `hcnt` wraps to 0 and `vcnt` increments.
  - `vcnt` wraps from `V_TOTAL-1` to 0.
- Shadow registers `trim_q` and `adj_q` load from `left_trim` and `hs_adj` only on the `ce_pix` cycle that produces `frame_start`, and also during `reset`. Input changes mid-frame have no effect until the next frame.
- Decode is computed from the next counter values and registered alongside them, so `hcnt`/`vcnt`/`hb`/`vb`/`hs`/`vs`/`de` always describe the same pixel:
  - `hb = (h < trim_q) | (h >= H_ACTIVE)`
  - `vb = (v >= V_ACTIVE)`
  - `hs = ~((h >= HS_START+adj_q) & (h < HS_END+adj_q))`, evaluated with sign-extended `adj_q` in width `clog2(H_TOTAL)+1`
  - `vs = ~((v >= VS_START) & (v < VS_END))`; it changes only together with `vcnt`, at `hcnt = 0`
- The `trim_q` and `adj_q` values used in the decode for the new frame's first pixel are the freshly loaded ones.
- `rgb_out = de ? rgb_in : 0`. This is combinational from the registered `de`.
- When `ce_pix` is low, every output holds, except that `line_start` and `frame_start` are 0.

## Timing
- Reset values:
  - `hcnt = H_TOTAL-1`, `vcnt = V_TOTAL-1`
  - `hb = vb = 1`, `hs = vs = 1`, `de = 0`
  - `line_start = frame_start = 0`
  - `rgb_out = 0`
  - `trim_q = left_trim`, `adj_q = hs_adj`
- The first `ce_pix` after reset moves to (0,0) and pulses both `frame_start` and `line_start`.
- Output latency is 0 cycles relative to the counters. Outputs update on the same `clk_sys` edge as the counter step.
- Reset asserted mid-frame overrides `ce_pix` and returns the block to the reset state on the next edge. There is no partial line.
- `ce_pix` held high continuously is legal, giving one pixel per `clk_sys`.
- A `left_trim` change landing on the same cycle as `frame_start` is captured for that frame.
- Frame period is `H_TOTAL*V_TOTAL` `ce_pix` cycles. With default parameters that is 81408.

## Test plan
- Reset, then `ce_pix` every cycle, `left_trim = 0`, `hs_adj = 0` → `frame_start` every 81408 cycles; `hs` low for `hcnt` 283..302 (20 pixels); `vs` low for `vcnt` 251..253 (954 pixels); `de` high for exactly 256x240 = 61440 pixels per frame.
- `ce_pix` every 10th `clk_sys` → counters step only on `ce_pix`; `frame_start` period is 814080 `clk_sys` cycles; pulses are 1 `clk_sys` wide.
- `left_trim = 5` → first `de` pixel of each active line at `hcnt = 5`; `rgb_in = 24'hFFFFFF` gives `rgb_out = 0` at `hcnt` 0..4 and 256..317; 251x240 active pixels per frame.
- `hs_adj = -3` driven at `vcnt = 100` → the rest of that frame keeps `hs` low at 283..302; from the next frame, `hs` is low at 280..299. `hs_adj = +7` moves it to 290..309.
- Reset asserted at `vcnt = 120`, `hcnt = 40` for one cycle → outputs take reset values, and the next `ce_pix` gives (0,0) with `frame_start = 1`.
- Parameter set `H_TOTAL=384`, `H_ACTIVE=320`, `HS_START=336`, `HS_END=368`, `V_TOTAL=262`, `V_ACTIVE=224`, `VS_START=234`, `VS_END=237` → `frame_start` period 100608 pixels; `hs` low 336..367; `vb` high for `vcnt` 224..261.
